serial_frame_rx: RTL and testbench
==================================

// Module: serial_frame_rx
// PURPOSE
//  Consumes the 1-bit serial line d and recovers framed words: idle high, start 0,
//  DATA_W data bits LSB first, stop 1. The bit rate is a fixed divisor of clk.
//  Presents each good word on a parallel bus with a one-cycle valid strobe.
//  It is the capture end of the bit-stream stimulus that drives the latch and DFF exercises.
// PARAMETERS
//  DATA_W        8   data bits per frame (1..16)
//  CLKS_PER_BIT  4   clk cycles per serial bit; even, >=2
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        synchronous, active-low reset
//  d          in   1        serial line, asynchronous to clk
//  rx_data    out  DATA_W   last good word
//  rx_valid   out  1        1-cycle pulse: rx_data just updated
//  frame_err  out  1        1-cycle pulse: stop bit sampled 0
//  parity_err out  1        1-cycle pulse: parity mismatch (0 without macro)
//  busy       out  1        high in any state other than IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE, sync flops=1, rx_data=0, rx_valid=0,
//    frame_err=0, parity_err=0, busy=0, counters=0. Reset mid-frame aborts the frame
//    and produces no pulse.
//  - d passes through a 2-flop synchronizer (reset to 1). The FSM uses only the
//    synchronized d_s.
//  - IDLE: d_s==0 -> START, clear bit counter.
//  - START: wait CLKS_PER_BIT/2 cycles. Then sample d_s: 0 -> DATA; 1 -> IDLE (glitch, no flag).
//  - DATA: sample every CLKS_PER_BIT cycles and shift into a shift register, LSB first.
//    After DATA_W samples -> PARITY (macro) or STOP.
//  - STOP: sample after CLKS_PER_BIT cycles.
//    - 1 -> rx_data<=shift, rx_valid=1 next cycle, -> IDLE.
//    - 0 -> frame_err=1 next cycle, rx_data holds, -> BREAK.
//  - BREAK: hold until d_s==1, then -> IDLE. A line held low never retriggers START.
//  - Latency: the falling edge of d at an edge is followed by rx_valid exactly
//    2 + CLKS_PER_BIT/2 + (DATA_W+1)*CLKS_PER_BIT cycles later (+CLKS_PER_BIT with parity).
//    Defaults give 40 cycles.
//  - Back-to-back frames: a start bit directly after the stop sample is accepted. The
//    IDLE->START decision occurs on the cycle following the return to IDLE.
//  - rx_valid, frame_err and parity_err are never high together. None stays high more
//    than 1 cycle.
// CONFIGURATION
//  SERIAL_RX_PARITY_EN defined:
//   - PARITY state after DATA expects an even-parity bit (XOR of data^parity == 0).
//   - Mismatch with a good stop -> parity_err pulse, rx_data holds, no rx_valid.
//   - Mismatch with a bad stop -> frame_err only.
//  Undefined: no PARITY state; parity_err tied 0.
// STRUCTURE
//  - Shared include ser_rx_defs.vh: state encodings (IDLE, START, DATA, PARITY, STOP,
//    BREAK, 3-bit), counter-width localparams.
//  - Sub-module bit_sync2: 2-flop synchronizer, sync active-low reset to 1. Reused by
//    other async-input blocks.
//  - Top level: FSM, baud counter ($clog2(CLKS_PER_BIT)), bit counter, shift register.
// TESTING
//  - Hold rst_n=0 4 cycles with d=0 -> all outputs 0, busy=0. Release with d=1
//    -> busy stays 0.
//  - Send 0xA5, defaults -> rx_valid 1 cycle with rx_data=8'hA5, 40 cycles after the
//    start edge; frame_err=0.
//  - Send 0x3C then 0xC3 back-to-back -> two rx_valid pulses, 40 cycles apart, data
//    3C then C3.
//  - Send 0x5A with stop=0 -> frame_err 1 cycle, rx_data keeps the previous word,
//    busy stays high until d=1.
//  - 1-cycle low glitch on idle line -> no pulse, busy returns 0 within
//    CLKS_PER_BIT/2+3 cycles.
//  - Drop rst_n mid-data of 0xFF -> no pulse, rx_data=0. With SERIAL_RX_PARITY_EN,
//    0x07 with parity 0 -> parity_err.

Source files
------------

// File: rtl/serial_frame_rx_pkg.sv
// serial_frame_rx_pkg: shared state encoding and counter sizing for the serial frame receiver
package serial_frame_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_sync2.sv
// bit_sync2: two-flop synchronizer for an asynchronous input, resets to 1 (idle-high line)
module bit_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // Shift the async input through two flops before anything else looks at it
    always_ff @(posedge clk) sync_q <= !rst_n ? 2'b11 : {sync_q[0], d_i};

    assign q_o = sync_q[1];

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: recovers start/data/stop framed words (LSB first) from a 1-bit serial line.
// Define SERIAL_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              busy
);

    localparam int            CW   = cnt_w(CLKS_PER_BIT);
    localparam int            BW   = cnt_w(DATA_W);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
`ifdef SERIAL_RX_PARITY_EN
    localparam rx_state_t     AFTER_DATA = ST_PARITY;
`else
    localparam rx_state_t     AFTER_DATA = ST_STOP;
`endif

    rx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              d_s;
    logic              baud_done;
`ifdef SERIAL_RX_PARITY_EN
    logic              par_q, par_d;
    logic              perr_q, perr_d;
`endif

    bit_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (d),
        .q_o   (d_s)
    );

    // START waits half a bit to land mid-bit; every later sample is a full bit apart
    assign baud_done = cnt_q == ((state_q == ST_START) ? HALF : FULL);

    // Next-state, sampling and result-strobe logic
    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == ST_IDLE || state_q == ST_BREAK || baud_done) ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                bit_d = '0;
                if (!d_s) state_d = ST_START;
            end
            ST_START: if (baud_done) state_d = d_s ? ST_IDLE : ST_DATA;
            ST_DATA: if (baud_done) begin
                shift_d = (shift_q >> 1) | (DATA_W'(d_s) << (DATA_W - 1));
                bit_d   = bit_q + 1'b1;
                if (bit_q == LAST) state_d = AFTER_DATA;
            end
`ifdef SERIAL_RX_PARITY_EN
            ST_PARITY: if (baud_done) begin
                par_d   = d_s;
                state_d = ST_STOP;
            end
`endif
            ST_STOP: if (baud_done) begin
                state_d = d_s ? ST_IDLE : ST_BREAK;
                ferr_d  = !d_s;
`ifdef SERIAL_RX_PARITY_EN
                perr_d  = d_s && (^shift_q != par_q);
                valid_d = d_s && (^shift_q == par_q);
`else
                valid_d = d_s;
`endif
                data_d  = valid_d ? shift_q : data_q;
            end
            ST_BREAK: if (d_s) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any frame in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef SERIAL_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = state_q != ST_IDLE;
`ifdef SERIAL_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed frames with hand-computed words, latencies and flag pulses
module tb_serial_frame_rx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SERIAL_RX_PARITY_EN
    localparam int PB  = 1;
`else
    localparam int PB  = 0;
`endif
    localparam int LAT   = 2 + CPB / 2 + (DW + 1 + PB) * CPB;
    localparam int FRAME = (DW + 2 + PB) * CPB;

    typedef struct {
        int            cyc;
        int            kind;
        logic [DW-1:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          d = 1'b1;
    logic [DW-1:0] rx_data;
    logic          rx_valid, frame_err, parity_err, busy;
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            multi_hi = 0;
    int            long_hi = 0;
    logic [2:0]    prev_flags = '0;
    ev_t           evq[$];

    serial_frame_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d          (d),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every flag pulse and watch for overlapping or stretched pulses
    always @(negedge clk) begin
        logic [2:0] f;
        f = {parity_err, frame_err, rx_valid};
        if ($countones(f) > 1) multi_hi++;
        if ((f & prev_flags) != 3'b000) long_hi++;
        prev_flags = f;
        if (rx_valid === 1'b1) evq.push_back('{cyc, 1, rx_data});
        if (frame_err === 1'b1) evq.push_back('{cyc, 2, rx_data});
        if (parity_err === 1'b1) evq.push_back('{cyc, 3, rx_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        d = b;
        tick(CPB);
    endtask

    // st is the cycle count just before the edge that first samples the start bit
    task automatic send_frame(input logic [DW-1:0] data, input logic par, input logic stop, output int st);
        st = cyc;
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) send_bit(data[i]);
        if (PB == 1) send_bit(par);
        send_bit(stop);
    endtask

    initial begin
        int   s1, s2;
        logic saw;

        d = 1'b0;
        rst_n = 1'b0;
        tick(4);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        d = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            tick(1);
            saw |= busy;
        end
        check("rel_busy_stays_0", saw, 0);

        evq.delete();
        send_frame(8'hA5, 1'b0, 1'b1, s1);
        d = 1'b1;
        tick(6);
        check("a5_events", evq.size(), 1);
        if (evq.size() == 1) begin
            check("a5_kind", evq[0].kind, 1);
            check("a5_data", evq[0].data, 8'hA5);
            check("a5_latency", evq[0].cyc - s1 - 1, LAT);
        end
        check("a5_rx_data", rx_data, 8'hA5);
        check("a5_busy", busy, 0);

        evq.delete();
        send_frame(8'h3C, 1'b0, 1'b1, s1);
        send_frame(8'hC3, 1'b0, 1'b1, s2);
        d = 1'b1;
        tick(6);
        check("b2b_events", evq.size(), 2);
        if (evq.size() == 2) begin
            check("b2b_kind0", evq[0].kind, 1);
            check("b2b_data0", evq[0].data, 8'h3C);
            check("b2b_kind1", evq[1].kind, 1);
            check("b2b_data1", evq[1].data, 8'hC3);
            check("b2b_latency", evq[0].cyc - s1 - 1, LAT);
            check("b2b_spacing", evq[1].cyc - evq[0].cyc, FRAME);
        end

        evq.delete();
        send_frame(8'h5A, 1'b0, 1'b0, s1);
        tick(20);
        check("ferr_events", evq.size(), 1);
        if (evq.size() == 1) begin
            check("ferr_kind", evq[0].kind, 2);
            check("ferr_latency", evq[0].cyc - s1 - 1, LAT);
        end
        check("ferr_rx_data_held", rx_data, 8'hC3);
        check("ferr_busy_while_low", busy, 1);
        d = 1'b1;
        tick(4);
        check("ferr_busy_released", busy, 0);
        check("ferr_no_retrigger", evq.size(), 1);

        evq.delete();
        d = 1'b0;
        tick(1);
        d = 1'b1;
        saw = 1'b0;
        repeat (CPB / 2 + 3) begin
            tick(1);
            saw |= busy;
        end
        check("glitch_saw_busy", saw, 1);
        check("glitch_busy_back", busy, 0);
        check("glitch_events", evq.size(), 0);

        evq.delete();
        d = 1'b0;
        tick(CPB);
        d = 1'b1;
        tick(3 * CPB);
        check("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(LAT + 10);
        check("midrst_events", evq.size(), 0);
        check("midrst_rx_data", rx_data, 0);
        check("midrst_busy", busy, 0);

        evq.delete();
        send_frame(8'h81, 1'b0, 1'b1, s1);
        d = 1'b1;
        tick(6);
        check("recover_events", evq.size(), 1);
        check("recover_rx_data", rx_data, 8'h81);

`ifdef SERIAL_RX_PARITY_EN
        evq.delete();
        send_frame(8'h07, 1'b0, 1'b1, s1);
        d = 1'b1;
        tick(6);
        check("perr_events", evq.size(), 1);
        if (evq.size() == 1) begin
            check("perr_kind", evq[0].kind, 3);
            check("perr_latency", evq[0].cyc - s1 - 1, LAT);
        end
        check("perr_rx_data_held", rx_data, 8'h81);

        evq.delete();
        send_frame(8'h07, 1'b0, 1'b0, s1);
        tick(4);
        d = 1'b1;
        tick(6);
        check("perr_badstop_events", evq.size(), 1);
        if (evq.size() == 1) check("perr_badstop_kind", evq[0].kind, 2);

        evq.delete();
        send_frame(8'h07, 1'b1, 1'b1, s1);
        d = 1'b1;
        tick(6);
        check("par_ok_events", evq.size(), 1);
        check("par_ok_rx_data", rx_data, 8'h07);
`endif

        check("pulse_exclusive", multi_hi, 0);
        check("pulse_width", long_hi, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
